// File: rtl/seq_wait_buf_if.sv
// seq_wait_buf_if
//   Bundles the enqueue, arbiter-loop, dequeue and flush signals of the
//   sequence-tagged holding buffer.
//   master : the side that offers requests, returns the arbiter's grants,
//            consumes dequeued entries and requests flushes.
//   slave  : the buffer itself.
//   Signals:
//     enq_seq_num/enq_data/enq_val -> , enq_rdy <-   request intake
//     arb_seq_num/arb_val <- , arb_gnt ->            arbiter loop
//     deq_seq_num/deq_data/deq_val <- , deq_rdy ->   issue port
//     flush ->                                        discard all entries
//     count <-                                        occupied entries
interface seq_wait_buf_if #(
  parameter int p_seq_num_bits = 5,
  parameter int p_data_bits    = 32,
  parameter int p_depth        = 4
);
  logic [p_seq_num_bits-1:0]              enq_seq_num;
  logic [p_data_bits-1:0]                 enq_data;
  logic                                   enq_val;
  logic                                   enq_rdy;
  logic [p_depth-1:0][p_seq_num_bits-1:0] arb_seq_num;
  logic [p_depth-1:0]                     arb_val;
  logic [p_depth-1:0]                     arb_gnt;
  logic [p_seq_num_bits-1:0]              deq_seq_num;
  logic [p_data_bits-1:0]                 deq_data;
  logic                                   deq_val;
  logic                                   deq_rdy;
  logic                                   flush;
  logic [$clog2(p_depth+1)-1:0]           count;

  modport master (
    output enq_seq_num, enq_data, enq_val, arb_gnt, deq_rdy, flush,
    input  enq_rdy, arb_seq_num, arb_val, deq_seq_num, deq_data, deq_val, count
  );

  modport slave (
    input  enq_seq_num, enq_data, enq_val, arb_gnt, deq_rdy, flush,
    output enq_rdy, arb_seq_num, arb_val, deq_seq_num, deq_data, deq_val, count
  );
endinterface

// File: rtl/seq_wait_buf.sv
// seq_wait_buf
//   Holds up to p_depth in-flight requests tagged with sequence numbers and
//   issues them in the order chosen by a downstream sequence arbiter. Every
//   entry's sequence number and occupied bit are exported to the arbiter; the
//   returned grant vector selects which entry is driven onto the dequeue port.
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - asynchronous active-low reset (clears occupancy and count)
//     bus  - seq_wait_buf_if.slave (enqueue, arbiter loop, dequeue, flush,
//            count)
module seq_wait_buf #(
  parameter int p_seq_num_bits = 5,
  parameter int p_data_bits    = 32,
  parameter int p_depth        = 4
) (
  input  logic clk,
  input  logic rst,
  seq_wait_buf_if.slave bus
);

  localparam int c_idx_bits = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int c_cnt_bits = $clog2(p_depth + 1);

  logic [p_depth-1:0]        valid_reg;
  logic [p_depth-1:0]        valid_next;
  logic [c_cnt_bits-1:0]     count_reg;
  logic [c_cnt_bits-1:0]     count_next;
  logic [p_seq_num_bits-1:0] seq_reg  [p_depth];
  logic [p_data_bits-1:0]    data_reg [p_depth];

  logic [c_idx_bits-1:0]     free_idx;
  logic [c_idx_bits-1:0]     sel_idx;
  logic [p_depth-1:0]        qual_gnt;
  logic                      deq_val;
  logic                      enq_rdy;
  logic                      enq_fire;
  logic                      deq_fire;

  // Lowest free entry, taken from pre-update state. Scanning downward lets
  // the last hit (the lowest index) win without needing a loop break.
  always_comb begin
    free_idx = '0;
    for (int i = p_depth - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        free_idx = c_idx_bits'(i);
      end
    end
  end

  // Grants on empty entries are stale and must be ignored. Duplicate
  // sequence numbers can raise several grant bits; the lowest index wins.
  assign qual_gnt = bus.arb_gnt & valid_reg;
  assign deq_val  = |qual_gnt;

  always_comb begin
    sel_idx = '0;
    for (int i = p_depth - 1; i >= 0; i--) begin
      if (qual_gnt[i]) begin
        sel_idx = c_idx_bits'(i);
      end
    end
  end

  // A slot freed by a dequeue this cycle is not offered until the next one,
  // so enq_rdy stays independent of deq_rdy.
  assign enq_rdy  = (count_reg < c_cnt_bits'(p_depth)) && !bus.flush;
  assign enq_fire = bus.enq_val && enq_rdy;
  // A flush swallows any concurrent dequeue even though deq_val may be high.
  assign deq_fire = deq_val && bus.deq_rdy && !bus.flush;

  // The enqueue target is always an empty entry while the dequeue target is
  // always an occupied one, so the two updates never collide.
  always_comb begin
    valid_next = valid_reg;
    count_next = count_reg;
    if (bus.flush) begin
      valid_next = '0;
      count_next = '0;
    end else begin
      if (deq_fire) begin
        valid_next[sel_idx] = 1'b0;
      end
      if (enq_fire) begin
        valid_next[free_idx] = 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_next = count_reg + c_cnt_bits'(1);
        2'b01:   count_next = count_reg - c_cnt_bits'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  // Payload storage carries no reset; contents of empty entries are unused.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      seq_reg[free_idx]  <= bus.enq_seq_num;
      data_reg[free_idx] <= bus.enq_data;
    end
  end

  generate
    for (genvar gi = 0; gi < p_depth; gi++) begin : g_arb
      assign bus.arb_seq_num[gi] = seq_reg[gi];
      assign bus.arb_val[gi]     = valid_reg[gi];
    end
  endgenerate

  assign bus.enq_rdy     = enq_rdy;
  assign bus.deq_val     = deq_val;
  assign bus.deq_seq_num = deq_val ? seq_reg[sel_idx]  : '0;
  assign bus.deq_data    = deq_val ? data_reg[sel_idx] : '0;
  assign bus.count       = count_reg;

endmodule

// File: tb/tb_seq_wait_buf.sv
// tb_seq_wait_buf
//   Directed table of vectors for the fill/drain/collision/flush corners,
//   async reset checks, then randomized traffic against a reference model of
//   the buffer's occupancy rules.
module tb_seq_wait_buf;
  localparam int D  = 4;
  localparam int SB = 5;
  localparam int DB = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_wait_buf_if #(.p_seq_num_bits(SB), .p_data_bits(DB), .p_depth(D)) bus();

  seq_wait_buf #(.p_seq_num_bits(SB), .p_data_bits(DB), .p_depth(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a set of occupied slots with their contents.
  bit          m_valid [D];
  logic [SB-1:0] m_seq [D];
  logic [DB-1:0] m_data[D];

  typedef struct {
    bit          ev;
    logic [SB-1:0] es;
    logic [D-1:0]  g;
    bit          dr;
    bit          fl;
    bit          x_rdy;
    bit          x_dv;
    logic [SB-1:0] x_seq;
    int          x_cnt;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic int m_sel(input logic [D-1:0] g);
    for (int i = 0; i < D; i++) if (g[i] && m_valid[i]) return i;
    return -1;
  endfunction

  function automatic logic [D-1:0] m_valid_vec();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = m_valid[i];
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_model();
    int c;
    int s;
    c = m_count();
    s = m_sel(bus.arb_gnt);
    check("count", 32'(bus.count), 32'(c));
    check("enq_rdy", 32'(bus.enq_rdy), 32'((c < D) && !bus.flush));
    check("deq_val", 32'(bus.deq_val), 32'(s >= 0));
    check("deq_seq_num", 32'(bus.deq_seq_num), (s >= 0) ? 32'(m_seq[s]) : 32'd0);
    check("deq_data", bus.deq_data, (s >= 0) ? m_data[s] : 32'd0);
    check("arb_val", 32'(bus.arb_val), 32'(m_valid_vec()));
    for (int i = 0; i < D; i++)
      if (m_valid[i]) check("arb_seq_num", 32'(bus.arb_seq_num[i]), 32'(m_seq[i]));
  endtask

  // Applies the clock edge's effect to the model using the inputs held
  // across that edge.
  task automatic model_edge();
    int c;
    int s;
    int f;
    bit ef;
    bit df;
    c = m_count();
    s = m_sel(bus.arb_gnt);
    f = -1;
    for (int i = D - 1; i >= 0; i--) if (!m_valid[i]) f = i;
    if (bus.flush) begin
      m_clear();
      $display("t=%0t flush", $time);
    end else begin
      ef = bus.enq_val && (c < D);
      df = (s >= 0) && bus.deq_rdy;
      if (df) m_valid[s] = 1'b0;
      if (ef) begin
        m_valid[f] = 1'b1;
        m_seq[f]   = bus.enq_seq_num;
        m_data[f]  = bus.enq_data;
      end
      if (ef || df)
        $display("t=%0t enq=%0d slot=%0d seq=%0h deq=%0d slot=%0d", $time,
                 ef, f, bus.enq_seq_num, df, s);
    end
  endtask

  task automatic cycle();
    #3;
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.enq_val     = 1'b0;
    bus.enq_seq_num = '0;
    bus.enq_data    = '0;
    bus.arb_gnt     = '0;
    bus.deq_rdy     = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic drive_random();
    int t;
    bus.enq_val     = ($urandom_range(0, 3) != 0);
    bus.enq_seq_num = SB'($urandom_range(0, 7));
    bus.enq_data    = $urandom;
    bus.deq_rdy     = ($urandom_range(0, 2) != 0);
    bus.flush       = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 1) == 0) begin
      bus.arb_gnt = D'($urandom);
    end else begin
      // Arbiter-like: grant every slot whose stored tag equals a chosen tag.
      t = $urandom_range(0, D - 1);
      for (int i = 0; i < D; i++) bus.arb_gnt[i] = (m_seq[i] === m_seq[t]);
    end
  endtask

  initial begin
    // Directed vectors: {enq_val, enq_seq, gnt, deq_rdy, flush,
    //                    exp enq_rdy, exp deq_val, exp deq_seq, exp count}
    tbl[0]  = '{1, 5'd3,  4'b0000, 0, 0, 1, 0, 5'd0,  0};
    tbl[1]  = '{1, 5'd1,  4'b0000, 0, 0, 1, 0, 5'd0,  1};
    tbl[2]  = '{1, 5'd2,  4'b0000, 0, 0, 1, 0, 5'd0,  2};
    tbl[3]  = '{1, 5'd0,  4'b0000, 0, 0, 1, 0, 5'd0,  3};
    tbl[4]  = '{1, 5'd7,  4'b0000, 1, 0, 0, 0, 5'd0,  4};
    tbl[5]  = '{0, 5'd0,  4'b1000, 1, 0, 0, 1, 5'd0,  4};
    tbl[6]  = '{0, 5'd0,  4'b0010, 1, 0, 1, 1, 5'd1,  3};
    tbl[7]  = '{0, 5'd0,  4'b0100, 1, 0, 1, 1, 5'd2,  2};
    tbl[8]  = '{0, 5'd0,  4'b0001, 1, 0, 1, 1, 5'd3,  1};
    tbl[9]  = '{0, 5'd0,  4'b1111, 1, 0, 1, 0, 5'd0,  0};
    tbl[10] = '{1, 5'd10, 4'b0000, 0, 0, 1, 0, 5'd0,  0};
    tbl[11] = '{1, 5'd11, 4'b0000, 0, 0, 1, 0, 5'd0,  1};
    tbl[12] = '{1, 5'd12, 4'b0000, 0, 0, 1, 0, 5'd0,  2};
    tbl[13] = '{1, 5'd5,  4'b0010, 1, 0, 1, 1, 5'd11, 3};
    tbl[14] = '{1, 5'd6,  4'b0000, 0, 0, 1, 0, 5'd0,  3};
    tbl[15] = '{0, 5'd0,  4'b1010, 1, 0, 0, 1, 5'd6,  4};
    tbl[16] = '{0, 5'd0,  4'b0100, 1, 0, 1, 1, 5'd12, 3};
    tbl[17] = '{0, 5'd0,  4'b0100, 1, 0, 1, 0, 5'd0,  2};
    tbl[18] = '{1, 5'd9,  4'b0001, 1, 1, 0, 1, 5'd10, 2};
    tbl[19] = '{0, 5'd0,  4'b1111, 1, 0, 1, 0, 5'd0,  0};

    m_clear();
    for (int i = 0; i < D; i++) begin
      m_seq[i]  = '0;
      m_data[i] = '0;
    end

    // Asynchronous reset with random inputs: empty immediately.
    rst = 1'b1;
    drive_idle();
    #2;
    rst = 1'b0;
    drive_random();
    bus.flush = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_arb_val", 32'(bus.arb_val), 32'd0);
    check("rst_deq_val", 32'(bus.deq_val), 32'd0);
    check("rst_enq_rdy", 32'(bus.enq_rdy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_count", 32'(bus.count), 32'd0);
    check("rst_hold_arb_val", 32'(bus.arb_val), 32'd0);
    drive_idle();
    rst = 1'b1;
    cycle();
    cycle();

    // Directed table.
    for (int i = 0; i < 20; i++) begin
      bus.enq_val     = tbl[i].ev;
      bus.enq_seq_num = tbl[i].es;
      bus.enq_data    = 32'h100 + 32'(tbl[i].es);
      bus.arb_gnt     = tbl[i].g;
      bus.deq_rdy     = tbl[i].dr;
      bus.flush       = tbl[i].fl;
      #3;
      check("tbl_enq_rdy", 32'(bus.enq_rdy), 32'(tbl[i].x_rdy));
      check("tbl_deq_val", 32'(bus.deq_val), 32'(tbl[i].x_dv));
      check("tbl_deq_seq", 32'(bus.deq_seq_num), 32'(tbl[i].x_seq));
      check("tbl_deq_data", bus.deq_data, tbl[i].x_dv ? 32'h100 + 32'(tbl[i].x_seq) : 32'd0);
      check("tbl_count", 32'(bus.count), 32'(tbl[i].x_cnt));
      check_model();
      @(posedge clk);
      model_edge();
      #1;
    end
    drive_idle();
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      drive_random();
      cycle();
    end

    // Reset asserted mid-transfer: buffer empties at once.
    drive_random();
    bus.flush   = 1'b0;
    bus.enq_val = 1'b1;
    bus.deq_rdy = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    m_clear();
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_arb_val", 32'(bus.arb_val), 32'd0);
    check("midrst_deq_val", 32'(bus.deq_val), 32'd0);
    check("midrst_enq_rdy", 32'(bus.enq_rdy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int n = 0; n < 100; n++) begin
      drive_random();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
